// File: rtl/vx_warp_issue_sched_pkg.sv
// rtl/vx_warp_issue_sched_pkg.sv - shared warp-count and branch-stall encodings
package vx_warp_issue_sched_pkg;

    localparam int NW   = 8;
    localparam int NW_W = $clog2(NW);

    // Same encoding the execute stage drives on its branch-stall output
    localparam logic STALL    = 1'b1;
    localparam logic NO_STALL = 1'b0;

endpackage

// File: rtl/vx_rr_pick.sv
// rtl/vx_rr_pick.sv - combinational rotate-priority pick, search begins one past start_i
module vx_rr_pick #(
    parameter int NW   = 8,
    parameter int NW_W = $clog2(NW)
) (
    input  logic [NW-1:0]   req_i,
    input  logic [NW_W-1:0] start_i,
    output logic            found_o,
    output logic [NW_W-1:0] idx_o
);

    logic [NW_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = NW; i >= 1; i--) begin
            cand = NW_W'(int'(start_i) + i);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/vx_warp_issue_sched.sv
// rtl/vx_warp_issue_sched.sv - round-robin warp issue scheduler with per-warp branch stall
module vx_warp_issue_sched
    import vx_warp_issue_sched_pkg::*;
#(
    parameter int NW   = vx_warp_issue_sched_pkg::NW,
    localparam int NW_W = $clog2(NW)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NW-1:0]   in_warp_active,
    input  logic            in_exe_ready,
    input  logic            in_branch_stall,
    input  logic [NW_W-1:0] in_branch_warp_num,
    input  logic            in_branch_resolve,
    input  logic [NW_W-1:0] in_resolve_warp_num,
    output logic            out_issue_valid,
    output logic [NW_W-1:0] out_issue_warp_num,
    output logic [NW-1:0]   out_stall_mask,
    output logic [NW_W:0]   out_num_stalled
);

    localparam logic [NW-1:0] ONE = {{(NW-1){1'b0}}, 1'b1};

    logic [NW-1:0]   stall_q, stall_d;
    logic [NW_W:0]   num_stalled_q, num_stalled_d;
    logic [NW_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            issue_valid_q, issue_valid_d;
    logic [NW_W-1:0] issue_warp_q, issue_warp_d;

    logic [NW-1:0]   set_vec, clr_vec, elig;
    logic            load, pick_found;
    logic [NW_W-1:0] pick_idx;

    assign set_vec = (in_branch_stall == STALL) ? (ONE << in_branch_warp_num) : '0;
    assign clr_vec = in_branch_resolve ? (ONE << in_resolve_warp_num) : '0;

    // Set wins over clear; the clear is not bypassed into eligibility
    assign stall_d = (stall_q & ~clr_vec) | set_vec;
    assign elig    = in_warp_active & ~stall_q & ~set_vec;
    assign load    = !issue_valid_q || in_exe_ready;

    vx_rr_pick #(
        .NW   (NW),
        .NW_W (NW_W)
    ) u_pick (
        .req_i   (elig),
        .start_i (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        num_stalled_d = '0;
        for (int i = 0; i < NW; i++) begin
            num_stalled_d = num_stalled_d + (NW_W+1)'(stall_d[i]);
        end
    end

    // A committed grant is held regardless of later activity or stall changes
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_warp_d  = issue_warp_q;
        rr_ptr_d      = rr_ptr_q;
        if (load) begin
            issue_valid_d = pick_found;
            if (pick_found) begin
                issue_warp_d = pick_idx;
                rr_ptr_d     = pick_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q       <= '0;
            num_stalled_q <= '0;
            rr_ptr_q      <= NW_W'(NW - 1);
            issue_valid_q <= 1'b0;
            issue_warp_q  <= '0;
        end else begin
            stall_q       <= stall_d;
            num_stalled_q <= num_stalled_d;
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_warp_q  <= issue_warp_d;
        end
    end

    assign out_issue_valid    = issue_valid_q;
    assign out_issue_warp_num = issue_warp_q;
    assign out_stall_mask     = stall_q;
    assign out_num_stalled    = num_stalled_q;

endmodule

// File: tb/tb_vx_warp_issue_sched.sv
// tb/tb_vx_warp_issue_sched.sv - directed self-checking bench for vx_warp_issue_sched
module tb_vx_warp_issue_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_warp_active;
    logic       in_exe_ready;
    logic       in_branch_stall;
    logic [2:0] in_branch_warp_num;
    logic       in_branch_resolve;
    logic [2:0] in_resolve_warp_num;
    logic       out_issue_valid;
    logic [2:0] out_issue_warp_num;
    logic [7:0] out_stall_mask;
    logic [3:0] out_num_stalled;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    vx_warp_issue_sched #(.NW(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in_warp_active      (in_warp_active),
        .in_exe_ready        (in_exe_ready),
        .in_branch_stall     (in_branch_stall),
        .in_branch_warp_num  (in_branch_warp_num),
        .in_branch_resolve   (in_branch_resolve),
        .in_resolve_warp_num (in_resolve_warp_num),
        .out_issue_valid     (out_issue_valid),
        .out_issue_warp_num  (out_issue_warp_num),
        .out_stall_mask      (out_stall_mask),
        .out_num_stalled     (out_num_stalled)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset               = 1'b1;
        in_warp_active      = 8'h00;
        in_exe_ready        = 1'b0;
        in_branch_stall     = 1'b0;
        in_branch_warp_num  = 3'd0;
        in_branch_resolve   = 1'b0;
        in_resolve_warp_num = 3'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_issue_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %0b want 0", out_issue_valid);
        end
        checks++;
        if (out_issue_warp_num !== 3'd0) begin
            fails++; $display("FAIL reset_warp got %0d want 0", out_issue_warp_num);
        end
        checks++;
        if (out_stall_mask !== 8'h00) begin
            fails++; $display("FAIL reset_mask got %h want 00", out_stall_mask);
        end
        checks++;
        if (out_num_stalled !== 4'd0) begin
            fails++; $display("FAIL reset_count got %0d want 0", out_num_stalled);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        in_warp_active = 8'hFF;
        in_exe_ready   = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (out_issue_valid !== 1'b1 || out_issue_warp_num !== 3'(k % 8)) begin
                fails++;
                $display("FAIL rr_grant[%0d] got v=%0b w=%0d want v=1 w=%0d",
                         k, out_issue_valid, out_issue_warp_num, k % 8);
            end
        end
    endtask

    task automatic test_hold();
        logic [2:0] exp_seq [4];
        exp_seq = '{3'd2, 3'd5, 3'd2, 3'd5};
        do_reset();
        in_warp_active = 8'b0010_0100;
        in_exe_ready   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (out_issue_valid !== 1'b1 || out_issue_warp_num !== exp_seq[k]) begin
                fails++;
                $display("FAIL alt_grant[%0d] got v=%0b w=%0d want v=1 w=%0d",
                         k, out_issue_valid, out_issue_warp_num, exp_seq[k]);
            end
        end
        in_exe_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_issue_valid !== 1'b1 || out_issue_warp_num !== 3'd5) begin
                fails++;
                $display("FAIL hold[%0d] got v=%0b w=%0d want v=1 w=5",
                         k, out_issue_valid, out_issue_warp_num);
            end
        end
        in_exe_ready = 1'b1;
        tick();
        checks++;
        if (out_issue_valid !== 1'b1 || out_issue_warp_num !== 3'd2) begin
            fails++;
            $display("FAIL after_hold got v=%0b w=%0d want v=1 w=2",
                     out_issue_valid, out_issue_warp_num);
        end
    endtask

    task automatic test_stall_resolve();
        do_reset();
        in_warp_active     = 8'h08;
        in_exe_ready       = 1'b1;
        in_branch_stall    = 1'b1;
        in_branch_warp_num = 3'd3;
        tick();
        in_branch_stall = 1'b0;
        checks++;
        if (out_issue_valid !== 1'b0) begin
            fails++; $display("FAIL stall_bypass got v=%0b want 0", out_issue_valid);
        end
        checks++;
        if (out_stall_mask !== 8'h08 || out_num_stalled !== 4'd1) begin
            fails++; $display("FAIL stall_mask got %h/%0d want 08/1", out_stall_mask, out_num_stalled);
        end
        tick();
        checks++;
        if (out_issue_valid !== 1'b0) begin
            fails++; $display("FAIL stall_hold got v=%0b want 0", out_issue_valid);
        end
        in_branch_resolve   = 1'b1;
        in_resolve_warp_num = 3'd3;
        tick();
        in_branch_resolve = 1'b0;
        checks++;
        if (out_stall_mask !== 8'h00 || out_issue_valid !== 1'b0) begin
            fails++;
            $display("FAIL resolve_t1 got mask=%h v=%0b want mask=00 v=0", out_stall_mask, out_issue_valid);
        end
        tick();
        checks++;
        if (out_issue_valid !== 1'b1 || out_issue_warp_num !== 3'd3) begin
            fails++;
            $display("FAIL resolve_t2 got v=%0b w=%0d want v=1 w=3", out_issue_valid, out_issue_warp_num);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        in_branch_stall     = 1'b1;
        in_branch_warp_num  = 3'd4;
        in_branch_resolve   = 1'b1;
        in_resolve_warp_num = 3'd4;
        tick();
        checks++;
        if (out_stall_mask !== 8'h10) begin
            fails++; $display("FAIL same_warp got %h want 10", out_stall_mask);
        end
        do_reset();
        in_branch_stall    = 1'b1;
        in_branch_warp_num = 3'd6;
        tick();
        checks++;
        if (out_stall_mask !== 8'h40) begin
            fails++; $display("FAIL pre_stall6 got %h want 40", out_stall_mask);
        end
        in_branch_warp_num  = 3'd1;
        in_branch_resolve   = 1'b1;
        in_resolve_warp_num = 3'd6;
        tick();
        in_branch_stall   = 1'b0;
        in_branch_resolve = 1'b0;
        checks++;
        if (out_stall_mask !== 8'h02 || out_num_stalled !== 4'd1) begin
            fails++; $display("FAIL diff_warp got %h/%0d want 02/1", out_stall_mask, out_num_stalled);
        end
    endtask

    task automatic test_all_stalled();
        do_reset();
        in_exe_ready    = 1'b1;
        in_branch_stall = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_branch_warp_num = 3'(k);
            tick();
        end
        in_branch_stall = 1'b0;
        in_warp_active  = 8'hFF;
        tick();
        checks++;
        if (out_stall_mask !== 8'hFF || out_num_stalled !== 4'd8) begin
            fails++; $display("FAIL all_mask got %h/%0d want FF/8", out_stall_mask, out_num_stalled);
        end
        checks++;
        if (out_issue_valid !== 1'b0) begin
            fails++; $display("FAIL all_valid got %0b want 0", out_issue_valid);
        end
        in_branch_resolve   = 1'b1;
        in_resolve_warp_num = 3'd0;
        tick();
        in_branch_resolve = 1'b0;
        checks++;
        if (out_stall_mask !== 8'hFE || out_issue_valid !== 1'b0) begin
            fails++;
            $display("FAIL all_res_t1 got mask=%h v=%0b want FE/0", out_stall_mask, out_issue_valid);
        end
        tick();
        checks++;
        if (out_issue_valid !== 1'b1 || out_issue_warp_num !== 3'd0) begin
            fails++;
            $display("FAIL all_res_t2 got v=%0b w=%0d want v=1 w=0", out_issue_valid, out_issue_warp_num);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_warp_active     = 8'h01;
        in_exe_ready       = 1'b1;
        in_branch_stall    = 1'b1;
        in_branch_warp_num = 3'd2;
        tick();
        in_exe_ready       = 1'b0;
        in_branch_warp_num = 3'd3;
        tick();
        in_branch_stall = 1'b0;
        checks++;
        if (out_issue_valid !== 1'b1 || out_issue_warp_num !== 3'd0 || out_stall_mask !== 8'h0C) begin
            fails++;
            $display("FAIL mid_pre got v=%0b w=%0d mask=%h want 1/0/0C",
                     out_issue_valid, out_issue_warp_num, out_stall_mask);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_issue_valid !== 1'b0 || out_issue_warp_num !== 3'd0 ||
            out_stall_mask !== 8'h00 || out_num_stalled !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset got v=%0b w=%0d mask=%h n=%0d want all 0",
                     out_issue_valid, out_issue_warp_num, out_stall_mask, out_num_stalled);
        end
        in_warp_active = 8'h30;
        in_exe_ready   = 1'b1;
        tick();
        checks++;
        if (out_issue_valid !== 1'b1 || out_issue_warp_num !== 3'd4) begin
            fails++;
            $display("FAIL mid_first got v=%0b w=%0d want v=1 w=4", out_issue_valid, out_issue_warp_num);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold();
        test_stall_resolve();
        test_same_cycle();
        test_all_stalled();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/vx_warp_issue_sched.md
# vx_warp_issue_sched

Round-robin warp scheduler that picks which warp issues into the execute stage each cycle. It holds per-warp branch-stall state: a warp that issues a branch or JAL is masked until its branch resolves. It sits between the warp/decode front end and the execute stage. It presents one registered issue grant at a time under a valid/ready handshake.

## Interface
- NW, 8, number of warps (power of two, 2..32)
- NW_W, $clog2(NW), warp-number width (derived, not overridden)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_warp_active  in  NW  bit w: warp w has a decoded instruction ready to issue
- in_exe_ready  in  1  execute stage accepts the current grant this cycle
- in_branch_stall  in  1  instruction in execute this cycle is a branch/JAL (STALL)
- in_branch_warp_num  in  NW_W  warp owning that branch/JAL
- in_branch_resolve  in  1  branch outcome for a warp is final; release its stall
- in_resolve_warp_num  in  NW_W  warp being released
- out_issue_valid  out  1  grant valid (registered)
- out_issue_warp_num  out  NW_W  granted warp (registered)
- out_stall_mask  out  NW  current per-warp branch-stall bits (registered)
- out_num_stalled  out  NW_W+1  population count of out_stall_mask (registered)

## Operation
- State:
  - stall_q[NW]
  - rr_ptr[NW_W] (last granted warp)
  - issue_valid_q
  - issue_warp_q
- Stall update each cycle:
  - stall_d = (stall_q & ~clr) | set.
  - clr is one-hot of in_resolve_warp_num when in_branch_resolve.
  - set is one-hot of in_branch_warp_num when in_branch_stall.
  - Set wins over clear on the same warp.
- Eligibility: elig = in_warp_active & ~stall_q & ~set.
  - A same-cycle set is bypassed, so the branching warp is never granted the next cycle.
  - A same-cycle clear is not bypassed, so the resolved warp is eligible one cycle later.
- Load condition: load = !issue_valid_q || in_exe_ready.
- On load:
  - Search elig starting at rr_ptr+1 (mod NW), wrapping; the first set bit wins.
  - If one is found: issue_valid_q<=1, issue_warp_q<=winner, rr_ptr<=winner.
  - If none is found: issue_valid_q<=0; issue_warp_q and rr_ptr hold.
- Without load, the grant is held unchanged. This applies even if the held warp drops in_warp_active or becomes stalled, because the grant is already committed.
- Only one branch per warp may be outstanding. in_branch_stall on a warp already stalled is a no-op (bit stays 1).
- in_branch_resolve on a non-stalled warp is a no-op.
- out_num_stalled = popcount(stall_q).

## Timing
- Reset values:
  - out_issue_valid=0
  - out_issue_warp_num=0
  - out_stall_mask=0
  - out_num_stalled=0
  - rr_ptr=NW-1, so warp 0 is first in priority after reset.
- Grant latency: 1 cycle from in_warp_active to out_issue_valid.
- Back-to-back grants are possible every cycle while in_exe_ready=1.
- Handshake: a transfer occurs on a cycle with out_issue_valid && in_exe_ready. While valid && !ready, out_issue_warp_num is stable.
- Stall latency: in_branch_stall at cycle t gives out_stall_mask bit set at t+1. The warp is excluded from the grant loaded at t+1.
- Resolve latency: in_branch_resolve at cycle t clears the bit at t+1. The warp's earliest grant is the one visible at t+2.
- Simultaneous stall and resolve:
  - Different warps: both apply.
  - Same warp: the bit ends set.
- Reset asserted mid-operation clears all state in the same edge; held grants and stalls are dropped.
- All elig bits zero: out_issue_valid=0 next cycle with no pointer movement.

## Structure
- Shared package/define file:
  - NW
  - NW_W
  - STALL/NO_STALL encodings (same values execute uses for out_branch_stall)
- Sub-module vx_rr_pick: purely combinational rotate-priority search.
  - Inputs: NW-bit request, NW_W-bit start pointer.
  - Outputs: found, NW_W index.
  - It is reusable by other warp arbiters.
- Stall register, popcount and handshake register remain in the top module.

## Test plan
- Reset, then in_warp_active=8'hFF, in_exe_ready=1 -> grants 0,1,2,...,7,0 on consecutive cycles starting one cycle after reset release.
- Active=8'b0010_0100, ready=1 -> alternating grants 2,5,2,5. in_exe_ready=0 for 3 cycles while the grant is 5 -> warp 5 held 3 cycles, then 2 follows.
- in_branch_stall=1 with warp 3, active=8'h08 -> no grant to warp 3 next cycle, out_stall_mask=8'h08, out_num_stalled=1. Resolve 3 at t -> mask clears at t+1, warp 3 granted at t+2.
- Same-cycle stall on warp 4 and resolve on warp 4 -> bit 4 remains set. Stall on 1 plus resolve on 6 (6 previously stalled) -> mask goes from 8'h40 to 8'h02.
- All warps stalled (mask=8'hFF), active=8'hFF -> out_issue_valid=0 with rr_ptr unchanged. Resolve 0 -> warp 0 granted two cycles later.
- Assert reset while a grant is held and mask=8'h0C -> next cycle all outputs zero. The first grant after release goes to the lowest active warp.
